// File: rtl/stb_host_bridge.sv
// Byte-stream command decoder bridging a host link to StreamTraceBuffer control/status/data ports.
// One command in flight; every STB and TX transfer waits on its ready/valid partner without any timeout.
module stb_host_bridge #(
  parameter int STAT_WIDTH = 8,
  parameter int CTRL_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic                  RX_VALID_I,
  output logic                  RX_READY_O,
  input  logic [7:0]            RX_DATA_I,
  output logic                  TX_VALID_O,
  input  logic                  TX_READY_I,
  output logic [7:0]            TX_DATA_O,
  output logic                  STATUS_READY_O,
  input  logic                  STATUS_VALID_I,
  input  logic [STAT_WIDTH-1:0] STATUS_I,
  output logic                  CONTROL_VALID_O,
  input  logic                  CONTROL_READY_I,
  output logic [CTRL_WIDTH-1:0] CONTROL_O,
  output logic                  WDATA_VALID_O,
  input  logic                  WDATA_READY_I,
  output logic [DATA_WIDTH-1:0] WDATA_O,
  output logic                  RDATA_READY_O,
  input  logic                  RDATA_VALID_I,
  input  logic [DATA_WIDTH-1:0] RDATA_I,
  output logic                  ERR_O
);

  localparam int NB_S   = (STAT_WIDTH + 7) / 8;
  localparam int NB_C   = (CTRL_WIDTH + 7) / 8;
  localparam int NB_D   = (DATA_WIDTH + 7) / 8;
  localparam int NB_SC  = (NB_S > NB_C) ? NB_S : NB_C;
  localparam int NB_MAX = (NB_SC > NB_D) ? NB_SC : NB_D;
  localparam int SH_W   = 8 * NB_MAX;
  localparam int CW     = $clog2(NB_MAX + 1);
  localparam int TW     = $clog2(TIMEOUT + 1);

  localparam logic [1:0] A_NOP  = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_DATA = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_PAY,
    S_WR_HS,
    S_RD_HS,
    S_TX_PAY
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [SH_W-1:0]       shadow_q, shadow_d;
  logic [SH_W-1:0]       txbuf_q, txbuf_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  rx_rdy;
  logic [CW-1:0]         nb_last;
  logic                  unused_cmd_bits;

  assign unused_cmd_bits = ^RX_DATA_I[6:2];

  always_comb begin
    case (addr_q)
      A_STAT:  nb_last = CW'(NB_S - 1);
      A_CTRL:  nb_last = CW'(NB_C - 1);
      default: nb_last = CW'(NB_D - 1);
    endcase
  end

  assign rx_rdy = (state_q == S_IDLE) || (state_q == S_RX_PAY);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    shadow_d = shadow_q;
    txbuf_d  = txbuf_q;
    ctrl_d   = ctrl_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RX_VALID_I) begin
          addr_d = RX_DATA_I[1:0];
          cnt_d  = '0;
          tmo_d  = '0;
          if (RX_DATA_I[1:0] != A_NOP) begin
            if (RX_DATA_I[7]) begin
              shadow_d = '0;
              state_d  = S_RX_PAY;
            end else if (RX_DATA_I[1:0] == A_CTRL) begin
              // Control readback comes from the local copy; STB is not involved.
              txbuf_d = SH_W'(ctrl_q);
              state_d = S_TX_PAY;
            end else begin
              state_d = S_RD_HS;
            end
          end
        end
      end

      S_RX_PAY: begin
        if (RX_VALID_I) begin
          shadow_d = shadow_q | (SH_W'(RX_DATA_I) << {cnt_q, 3'b000});
          tmo_d    = '0;
          if (cnt_q == nb_last) begin
            case (addr_q)
              A_CTRL: begin
                ctrl_d  = shadow_d[CTRL_WIDTH-1:0];
                state_d = S_WR_HS;
              end
              A_DATA: begin
                wdata_d = shadow_d[DATA_WIDTH-1:0];
                state_d = S_WR_HS;
              end
              default: begin
                // Status is read-only: the whole frame is consumed, then flagged.
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_WR_HS: begin
        if ((addr_q == A_CTRL && CONTROL_READY_I) || (addr_q == A_DATA && WDATA_READY_I)) begin
          state_d = S_IDLE;
        end
      end

      S_RD_HS: begin
        cnt_d = '0;
        if (addr_q == A_STAT && STATUS_VALID_I) begin
          txbuf_d = SH_W'(STATUS_I);
          state_d = S_TX_PAY;
        end else if (addr_q == A_DATA && RDATA_VALID_I) begin
          txbuf_d = SH_W'(RDATA_I);
          state_d = S_TX_PAY;
        end
      end

      S_TX_PAY: begin
        if (TX_READY_I) begin
          txbuf_d = txbuf_q >> 8;
          if (cnt_q == nb_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q  <= S_IDLE;
      addr_q   <= A_NOP;
      cnt_q    <= '0;
      tmo_q    <= '0;
      shadow_q <= '0;
      txbuf_q  <= '0;
      ctrl_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      shadow_q <= shadow_d;
      txbuf_q  <= txbuf_d;
      ctrl_q   <= ctrl_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // Gated by reset so RX_READY_O is low in reset yet high in the very first cycle after it.
  assign RX_READY_O      = RST_NI & rx_rdy;
  assign TX_VALID_O      = (state_q == S_TX_PAY);
  assign TX_DATA_O       = txbuf_q[7:0];
  assign STATUS_READY_O  = (state_q == S_RD_HS) && (addr_q == A_STAT);
  assign RDATA_READY_O   = (state_q == S_RD_HS) && (addr_q == A_DATA);
  assign CONTROL_VALID_O = (state_q == S_WR_HS) && (addr_q == A_CTRL);
  assign WDATA_VALID_O   = (state_q == S_WR_HS) && (addr_q == A_DATA);
  assign CONTROL_O       = ctrl_q;
  assign WDATA_O         = wdata_q;
  assign ERR_O           = err_q;

endmodule
